ahbl_splitter: RTL and testbench
================================

AHBL_SPLITTER -- requirements
Module: ahbl_splitter

Interface
REQ-001 Parameter N_PORTS, 2, number of downstream slave ports.
REQ-002 Parameter W_ADDR, 32, address width.
REQ-003 Parameter W_DATA, 32, data width.
REQ-004 Parameter ADDR_MAP, N_PORTS*W_ADDR bits, base address of port i in field i (all zero by default).
REQ-005 Parameter ADDR_MASK, N_PORTS*W_ADDR bits, decode mask of port i in field i (all zero by default).
REQ-006 Ports: clk, in, 1, sole clock (rising edge); rst_n, in, 1, reset, asynchronous, active-low.
REQ-007 Ports: src_hready in 1, src_hready_resp out 1, src_hresp out 1: upstream bus handshake and response.
REQ-008 Ports: src_haddr in W_ADDR, src_hwrite in 1, src_htrans in 2, src_hsize in 3, src_hburst in 3, src_hprot in 4, src_hmastlock in 1: upstream address phase.
REQ-009 Ports: src_hwdata in W_DATA, src_hrdata out W_DATA: upstream data phase.
REQ-010 Ports: dst_hready out N_PORTS, dst_hready_resp in N_PORTS, dst_hresp in N_PORTS: per-slave handshake.
REQ-011 Ports: dst_haddr out N_PORTS*W_ADDR, dst_hwrite out N_PORTS, dst_htrans out N_PORTS*2, dst_hsize out N_PORTS*3, dst_hburst out N_PORTS*3, dst_hprot out N_PORTS*4, dst_hmastlock out N_PORTS: per-slave address phase, port i in field i.
REQ-012 Ports: dst_hwdata out N_PORTS*W_DATA, dst_hrdata in N_PORTS*W_DATA: per-slave data phase.

Function
REQ-013 Port i SHALL match when (src_haddr & ADDR_MASK[i]) == ADDR_MAP[i]; on multiple matches, lowest index wins (one-hot addr-phase select).
REQ-014 dst_htrans[i] SHALL equal src_htrans when port i selected, else 2'b00 (IDLE); all other addr-phase signals broadcast unmodified to every port.
REQ-015 dst_hready[i] SHALL equal src_hready for all i; dst_hwdata broadcast src_hwdata to all ports.
REQ-016 Data-phase select register sel_d (N_PORTS, one-hot or zero) SHALL load on clk rising edge when src_hready=1: addr-phase select if src_htrans[1]=1, else zero; holds otherwise.
REQ-017 With sel_d nonzero, src_hready_resp, src_hresp, src_hrdata SHALL be those of the selected port, zero latency.
REQ-018 With sel_d zero and error FSM in IDLE: src_hready_resp=1, src_hresp=0, src_hrdata=0.
REQ-019 Error FSM states IDLE, ERR1, ERR2; IDLE->ERR1 on edge with src_hready=1, src_htrans[1]=1, no port matched.
REQ-020 ERR1: src_hready_resp=0, src_hresp=1; unconditionally -> ERR2 next cycle.
REQ-021 ERR2: src_hready_resp=1, src_hresp=1; -> ERR1 if another unmapped active transfer presented, else IDLE (sel_d loaded per REQ-016).
REQ-022 An unmapped transfer SHALL never assert dst_htrans[1] on any port.
REQ-023 IDLE/BUSY (src_htrans[1]=0) transfers SHALL never enter ERR1 nor select a port in data phase.
REQ-024 Slave two-cycle ERROR responses SHALL pass through unaltered; splitter adds no state for them.
REQ-025 Back-to-back transfers to different ports SHALL incur no added wait states.

Reset
REQ-026 On rst_n low, asynchronously: sel_d=0, FSM=IDLE; hence src_hready_resp=1, src_hresp=0, src_hrdata=0.
REQ-027 Combinational outputs (dst_* address phase) SHALL follow src inputs during reset; dst_htrans still decoded.
REQ-028 Reset asserted mid-ERR1/ERR2 SHALL return FSM to IDLE immediately; first post-reset cycle responds OKAY.

Verification
REQ-029 N_PORTS=2, map0=0x0000_0000/mask 0xF000_0000, map1=0x1000_0000/same mask; NONSEQ read 0x1000_0004 -> dst_htrans[1]=2, dst_htrans[0]=0; next cycle src_hrdata=dst_hrdata port 1.
REQ-030 Port-0 write then port-1 read back-to-back, port 0 stalls 2 cycles -> src_hready_resp low 2 cycles, port-1 address held until release, no extra wait states.
REQ-031 NONSEQ to 0x2000_0000 (unmapped) -> no dst_htrans active; cycle1 hready_resp=0/hresp=1, cycle2 hready_resp=1/hresp=1, then OKAY.
REQ-032 Two consecutive unmapped transfers -> ERR1,ERR2,ERR1,ERR2 sequence, then IDLE.
REQ-033 Slave port 1 returns ERROR -> src_hresp/src_hready_resp mirror port 1 exactly for both cycles.
REQ-034 rst_n pulsed low during ERR1 -> src_hready_resp=1, src_hresp=0 immediately, sel_d=0.

Source files
------------

// File: rtl/ahbl_splitter.sv
// AHB-Lite 1-to-N address splitter: decodes the upstream address phase onto N slave ports,
// steers the data-phase response back, and answers unmapped transfers with a two-cycle ERROR.
module ahbl_splitter #(
  parameter int                          N_PORTS   = 2,
  parameter int                          W_ADDR    = 32,
  parameter int                          W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = '0,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // Upstream handshake: a transfer is taken on a rising edge where src_hready=1 and
  // src_htrans[1]=1; src_hready_resp=0 stretches the current data phase.
  input  logic                           src_hready,
  output logic                           src_hready_resp,
  output logic                           src_hresp,
  input  logic [W_ADDR-1:0]              src_haddr,
  input  logic                           src_hwrite,
  input  logic [1:0]                     src_htrans,
  input  logic [2:0]                     src_hsize,
  input  logic [2:0]                     src_hburst,
  input  logic [3:0]                     src_hprot,
  input  logic                           src_hmastlock,
  input  logic [W_DATA-1:0]              src_hwdata,
  output logic [W_DATA-1:0]              src_hrdata,
  output logic [N_PORTS-1:0]             dst_hready,
  input  logic [N_PORTS-1:0]             dst_hready_resp,
  input  logic [N_PORTS-1:0]             dst_hresp,
  output logic [N_PORTS*W_ADDR-1:0]      dst_haddr,
  output logic [N_PORTS-1:0]             dst_hwrite,
  output logic [N_PORTS*2-1:0]           dst_htrans,
  output logic [N_PORTS*3-1:0]           dst_hsize,
  output logic [N_PORTS*3-1:0]           dst_hburst,
  output logic [N_PORTS*4-1:0]           dst_hprot,
  output logic [N_PORTS-1:0]             dst_hmastlock,
  output logic [N_PORTS*W_DATA-1:0]      dst_hwdata,
  input  logic [N_PORTS*W_DATA-1:0]      dst_hrdata,
  output logic [1:0]                     err_state_o,
  output logic [N_PORTS-1:0]             data_sel_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

  err_state_t           state_q;
  logic                 err_active_q;
  logic                 err_wait_q;
  logic [N_PORTS-1:0]   data_sel_q;
  logic [N_PORTS-1:0]   data_sel_d;
  logic [N_PORTS-1:0]   addr_sel;
  logic                 addr_hit;
  logic                 unmapped_active;

  // Lowest matching index wins, so addr_sel is always one-hot or zero.
  always_comb begin
    addr_sel = '0;
    addr_hit = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!addr_hit &&
          ((src_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR])) begin
        addr_sel[i] = 1'b1;
        addr_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    dst_htrans = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (addr_sel[i]) dst_htrans[i*2 +: 2] = src_htrans;
    end
  end

  assign dst_haddr     = {N_PORTS{src_haddr}};
  assign dst_hwrite    = {N_PORTS{src_hwrite}};
  assign dst_hsize     = {N_PORTS{src_hsize}};
  assign dst_hburst    = {N_PORTS{src_hburst}};
  assign dst_hprot     = {N_PORTS{src_hprot}};
  assign dst_hmastlock = {N_PORTS{src_hmastlock}};
  assign dst_hready    = {N_PORTS{src_hready}};
  assign dst_hwdata    = {N_PORTS{src_hwdata}};

  assign unmapped_active = src_hready & src_htrans[1] & ~addr_hit;

  always_comb begin
    data_sel_d = data_sel_q;
    if (src_hready) data_sel_d = src_htrans[1] ? addr_sel : '0;
  end

  // Error responder; err_active_q/err_wait_q are the registered forms of the response it drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      err_active_q <= 1'b0;
      err_wait_q   <= 1'b0;
      data_sel_q   <= '0;
    end else begin
      data_sel_q <= data_sel_d;
      case (state_q)
        ST_ERR1: begin
          state_q      <= ST_ERR2;
          err_active_q <= 1'b1;
          err_wait_q   <= 1'b0;
        end
        default: begin
          if (unmapped_active) begin
            state_q      <= ST_ERR1;
            err_active_q <= 1'b1;
            err_wait_q   <= 1'b1;
          end else begin
            state_q      <= ST_IDLE;
            err_active_q <= 1'b0;
            err_wait_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = 1'b0;
    src_hrdata      = '0;
    if (err_active_q) begin
      src_hready_resp = ~err_wait_q;
      src_hresp       = 1'b1;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (data_sel_q[i]) begin
          src_hready_resp = dst_hready_resp[i];
          src_hresp       = dst_hresp[i];
          src_hrdata      = dst_hrdata[i*W_DATA +: W_DATA];
        end
      end
    end
  end

  assign err_state_o = state_q;
  assign data_sel_o  = data_sel_q;

endmodule

// File: tb/tb_ahbl_splitter.sv
// Directed + randomized bench for ahbl_splitter with a transaction-level reference model.
module tb_ahbl_splitter;

  localparam logic [63:0] MAP  = {32'h1000_0000, 32'h0000_0000};
  localparam logic [63:0] MASK = {32'hF000_0000, 32'hF000_0000};
  localparam int PH_NONE = -1;
  localparam int PH_E1   = 10;
  localparam int PH_E2   = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_hready, src_hready_resp, src_hresp;
  logic [31:0] src_haddr;
  logic        src_hwrite;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize, src_hburst;
  logic [3:0]  src_hprot;
  logic        src_hmastlock;
  logic [31:0] src_hwdata, src_hrdata;
  logic [1:0]  dst_hready, dst_hready_resp, dst_hresp;
  logic [63:0] dst_haddr;
  logic [1:0]  dst_hwrite;
  logic [3:0]  dst_htrans;
  logic [5:0]  dst_hsize, dst_hburst;
  logic [7:0]  dst_hprot;
  logic [1:0]  dst_hmastlock;
  logic [63:0] dst_hwdata, dst_hrdata;
  logic [1:0]  err_state;
  logic [1:0]  data_sel;

  int checks = 0;
  int errors = 0;

  // Reference model state: which responder owns the current data phase.
  int          ph;
  bit          rand_slaves;
  logic [1:0]  plan0_q[$];
  logic [1:0]  plan1_q[$];
  logic [31:0] cur_addr;
  logic [1:0]  cur_trans;
  logic        cur_write, cur_lock;
  logic [2:0]  cur_size, cur_burst;
  logic [3:0]  cur_prot;

  ahbl_splitter #(
    .N_PORTS(2), .W_ADDR(32), .W_DATA(32), .ADDR_MAP(MAP), .ADDR_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
    .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
    .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
    .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
    .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata),
    .err_state_o(err_state), .data_sel_o(data_sel)
  );

  always #5 clk = ~clk;

  // Address map in plain terms: region 0x0xxx_xxxx is port 0, 0x1xxx_xxxx is port 1.
  function automatic int target(input logic [31:0] a);
    int region;
    region = int'(a[31:28]);
    return (region <= 1) ? region : -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_slaves();
    logic [1:0] pl;
    for (int p = 0; p < 2; p++) begin
      if (p == 0 && plan0_q.size() > 0)      pl = plan0_q.pop_front();
      else if (p == 1 && plan1_q.size() > 0) pl = plan1_q.pop_front();
      else if (rand_slaves)                  pl = {($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0)};
      else                                   pl = 2'b10;
      dst_hready_resp[p]     = pl[1];
      dst_hresp[p]           = pl[0];
      dst_hrdata[p*32 +: 32] = $urandom;
    end
  endtask

  task automatic drive_src(input logic rdy);
    src_haddr     = cur_addr;
    src_htrans    = cur_trans;
    src_hwrite    = cur_write;
    src_hsize     = cur_size;
    src_hburst    = cur_burst;
    src_hprot     = cur_prot;
    src_hmastlock = cur_lock;
    src_hready    = rdy;
    src_hwdata    = $urandom;
  endtask

  // One bus cycle: drive, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(output bit acc);
    logic        e_ready, e_resp;
    logic [31:0] e_rdata;
    logic [1:0]  e_sel;
    logic [3:0]  e_htrans;
    int          t;
    @(negedge clk);
    drive_slaves();
    e_ready = 1'b1; e_resp = 1'b0; e_rdata = '0; e_sel = 2'b00;
    if (ph == 0 || ph == 1) begin
      e_ready   = dst_hready_resp[ph];
      e_resp    = dst_hresp[ph];
      e_rdata   = dst_hrdata[ph*32 +: 32];
      e_sel[ph] = 1'b1;
    end else if (ph == PH_E1) begin
      e_ready = 1'b0; e_resp = 1'b1;
    end else if (ph == PH_E2) begin
      e_ready = 1'b1; e_resp = 1'b1;
    end
    drive_src(e_ready);
    t = target(cur_addr);
    e_htrans = '0;
    if (t >= 0) e_htrans[t*2 +: 2] = cur_trans;
    #1;
    chk("dst_htrans", 64'(dst_htrans), 64'(e_htrans));
    chk("dst_haddr", dst_haddr, {cur_addr, cur_addr});
    chk("dst_hready", 64'(dst_hready), 64'({2{e_ready}}));
    chk("dst_hwdata", dst_hwdata, {src_hwdata, src_hwdata});
    chk("dst_ctrl", 64'({dst_hwrite, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock}),
        64'({{2{cur_write}}, {2{cur_size}}, {2{cur_burst}}, {2{cur_prot}}, {2{cur_lock}}}));
    chk("src_hready_resp", 64'(src_hready_resp), 64'(e_ready));
    chk("src_hresp", 64'(src_hresp), 64'(e_resp));
    chk("src_hrdata", 64'(src_hrdata), 64'(e_rdata));
    chk("data_sel", 64'(data_sel), 64'(e_sel));
    @(posedge clk);
    acc = src_hready;
    if (ph == PH_E1) ph = PH_E2;
    else if (src_hready) begin
      if (!cur_trans[1]) ph = PH_NONE;
      else ph = (t < 0) ? PH_E1 : t;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] tr, output int n);
    bit acc;
    cur_addr  = a;
    cur_trans = tr;
    cur_write = 1'($urandom);
    cur_size  = 3'($urandom);
    cur_burst = 3'($urandom);
    cur_prot  = 4'($urandom);
    cur_lock  = 1'($urandom);
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      cycle(acc);
      n++;
    end
    chk("accept_bound", 64'(acc), 64'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    rand_slaves = 1'b0;
    ph = PH_NONE;
    cur_addr = 32'h1000_0004; cur_trans = 2'b10; cur_write = 1'b0;
    cur_size = 3'd2; cur_burst = 3'd0; cur_prot = 4'd3; cur_lock = 1'b0;
    drive_src(1'b1);
    drive_slaves();
    #1;
    // Reset: responses idle, address phase still decoded.
    chk("rst_hready_resp", 64'(src_hready_resp), 64'd1);
    chk("rst_hresp", 64'(src_hresp), 64'd0);
    chk("rst_hrdata", 64'(src_hrdata), 64'd0);
    chk("rst_dst_htrans", 64'(dst_htrans), 64'h8);
    chk("rst_data_sel", 64'(data_sel), 64'd0);
    repeat (2) @(negedge clk);
    cur_trans = 2'b00; src_htrans = 2'b00;
    rst_n = 1'b1;

    // Mapped read to port 1, then its data phase.
    issue(32'h1000_0004, 2'b10, n);
    issue(32'h0000_0000, 2'b00, n);
    chk("p1_read_latency", 64'(n), 64'd1);

    // Port-0 write stalled two cycles while port-1 read waits.
    issue(32'h0000_0010, 2'b10, n);
    plan0_q.push_back(2'b00);
    plan0_q.push_back(2'b00);
    issue(32'h1000_0020, 2'b10, n);
    chk("stall_cycles", 64'(n), 64'd3);
    issue(32'h0000_0000, 2'b00, n);
    chk("b2b_no_wait", 64'(n), 64'd1);

    // Single unmapped transfer.
    issue(32'h2000_0000, 2'b10, n);
    issue(32'h0000_0000, 2'b00, n);
    chk("unmapped_len", 64'(n), 64'd2);
    issue(32'h0000_0000, 2'b00, n);

    // Two consecutive unmapped transfers.
    issue(32'h2000_0100, 2'b10, n);
    issue(32'h3000_0000, 2'b10, n);
    chk("unmapped2_first", 64'(n), 64'd2);
    issue(32'h0000_0000, 2'b00, n);
    chk("unmapped2_second", 64'(n), 64'd2);

    // Slave error response from port 1 passes through.
    issue(32'h1000_0000, 2'b10, n);
    plan1_q.push_back(2'b01);
    plan1_q.push_back(2'b11);
    issue(32'h0000_0000, 2'b00, n);
    chk("slave_err_len", 64'(n), 64'd2);

    // Reset during ERR1.
    issue(32'h4000_0000, 2'b10, n);
    @(negedge clk);
    cur_trans = 2'b00; src_htrans = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("err_rst_hready_resp", 64'(src_hready_resp), 64'd1);
    chk("err_rst_hresp", 64'(src_hresp), 64'd0);
    chk("err_rst_data_sel", 64'(data_sel), 64'd0);
    ph = PH_NONE;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0000_0040, 2'b10, n);
    chk("post_rst_okay", 64'(n), 64'd1);

    // Randomized traffic with random slave responses.
    rand_slaves = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 5)), 28'($urandom)};
      issue(a, 2'($urandom), n);
    end
    rand_slaves = 1'b0;
    repeat (3) issue(32'h0000_0000, 2'b00, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
